// File: rtl/matmul_output_writer_pkg.sv
// Shared types and helpers for the matmul output writer: FSM encoding,
// row-index width and the packing offset of one column word.
package matmul_output_writer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int DEFAULT_ROWS = 4;

  // Wide enough to hold 0..ROWS, so a count can reach "all rows delivered".
  function automatic int row_idx_w(input int rows);
    return $clog2(rows + 1);
  endfunction

  localparam int ROW_IDX_W = row_idx_w(DEFAULT_ROWS);

  function automatic int word_lo(input int col, input int word_size);
    return col * word_size;
  endfunction

endpackage

// File: rtl/output_row_buffer.sv
// ROWS x COLS result buffer: each column writes its own row index,
// and one full result row is read out combinationally.
module output_row_buffer
  import matmul_output_writer_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int IDX_W     = ROW_IDX_W
) (
  input  logic                      clk,
  input  logic [COLS-1:0]           wr_en,
  input  logic [COLS*IDX_W-1:0]     wr_idx,
  input  logic [COLS*WORD_SIZE-1:0] wr_data,
  input  logic [IDX_W-1:0]          rd_idx,
  output logic [COLS*WORD_SIZE-1:0] rd_data
);

  logic [WORD_SIZE-1:0] mem [ROWS][COLS];

  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        if (wr_en[c] && wr_idx[c*IDX_W +: IDX_W] == IDX_W'(r))
          mem[r][c] <= wr_data[word_lo(c, WORD_SIZE) +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (rd_idx == IDX_W'(r))
          rd_data[word_lo(c, WORD_SIZE) +: WORD_SIZE] = mem[r][c];
      end
    end
  end

endmodule

// File: rtl/matmul_output_writer.sv
// De-skews per-column systolic results into full rows and writes them,
// in row order, one memory word per row.
//
// state   | meaning
// IDLE    | waiting for start; col_valid ignored
// COLLECT | capturing column words, writing completed rows in order
// DONE    | last row write issued; done pulses, then back to IDLE
module matmul_output_writer
  import matmul_output_writer_pkg::*;
#(
  parameter int          ROWS      = 4,
  parameter int          COLS      = 4,
  parameter int          WORD_SIZE = 16,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COLS-1:0]           col_valid,
  input  logic [COLS*WORD_SIZE-1:0] bottom_out_bus,
  output logic                      output_mem_wr_en,
  output logic [31:0]               output_mem_addr,
  output logic [COLS*WORD_SIZE-1:0] output_mem_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int IW = row_idx_w(ROWS);

  state_t                    state, state_next;
  logic [IW-1:0]             col_cnt  [COLS];
  logic [IW-1:0]             cnt_next [COLS];
  logic [COLS-1:0]           cap, full;
  logic [COLS*IW-1:0]        buf_idx;
  logic [ROWS-1:0]           row_done, row_done_next;
  logic [IW-1:0]             wr_row;
  logic                      wr_sel, wr_fire;
  logic [COLS*WORD_SIZE-1:0] rd_data;

  output_row_buffer #(
    .ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WORD_SIZE), .IDX_W(IW)
  ) u_buf (
    .clk    (clk),
    .wr_en  (cap),
    .wr_idx (buf_idx),
    .wr_data(bottom_out_bus),
    .rd_idx (wr_row),
    .rd_data(rd_data)
  );

  always_comb begin
    logic all_cols;
    cap           = '0;
    full          = '0;
    buf_idx       = '0;
    row_done_next = row_done;
    wr_sel        = 1'b0;
    all_cols      = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      full[c]                = col_cnt[c] >= IW'(ROWS);
      cap[c]                 = (state == COLLECT) && col_valid[c] && !full[c];
      cnt_next[c]            = col_cnt[c] + IW'(cap[c]);
      buf_idx[c*IW +: IW]    = col_cnt[c];
    end
    // A row is complete once every column's count has moved past it.
    for (int r = 0; r < ROWS; r++) begin
      all_cols = 1'b1;
      for (int c = 0; c < COLS; c++) begin
        if (cnt_next[c] <= IW'(r)) all_cols = 1'b0;
      end
      if (all_cols) row_done_next[r] = 1'b1;
      if (wr_row == IW'(r)) wr_sel = row_done[r];
    end
    wr_fire = (state == COLLECT) && wr_sel;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (wr_fire && wr_row == IW'(ROWS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < COLS; c++) col_cnt[c] <= '0;
      row_done           <= '0;
      wr_row             <= '0;
      overflow           <= 1'b0;
      output_mem_wr_en   <= 1'b0;
      output_mem_addr    <= '0;
      output_mem_wr_data <= '0;
    end else begin
      output_mem_wr_en <= 1'b0;
      if (state == IDLE && start) begin
        for (int c = 0; c < COLS; c++) col_cnt[c] <= '0;
        row_done <= '0;
        wr_row   <= '0;
        overflow <= 1'b0;
      end else if (state == COLLECT) begin
        for (int c = 0; c < COLS; c++) col_cnt[c] <= cnt_next[c];
        row_done <= row_done_next;
        if (|(col_valid & full)) overflow <= 1'b1;
        if (wr_fire) begin
          output_mem_wr_en   <= 1'b1;
          output_mem_addr    <= BASE_ADDR + 32'(wr_row);
          output_mem_wr_data <= rd_data;
          wr_row             <= wr_row + 1'b1;
        end
      end
    end
  end

  assign busy = (state == COLLECT);
  assign done = (state == DONE);

endmodule

// File: tb/tb_matmul_output_writer.sv
// Directed bench for matmul_output_writer: skewed, simultaneous and stalled
// column delivery, overflow, restart attempts and mid-run reset.
module tb_matmul_output_writer;

  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst, start;
  logic [C-1:0]   col_valid;
  logic [C*W-1:0] bus;

  logic           wr_en0, busy0, done0, ov0;
  logic [31:0]    addr0;
  logic [C*W-1:0] data0;
  logic           wr_en16, busy16, done16, ov16;
  logic [31:0]    addr16;
  logic [C*W-1:0] data16;

  matmul_output_writer #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .BASE_ADDR(32'd0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .bottom_out_bus(bus),
    .output_mem_wr_en(wr_en0), .output_mem_addr(addr0), .output_mem_wr_data(data0),
    .busy(busy0), .done(done0), .overflow(ov0)
  );

  matmul_output_writer #(.ROWS(R), .COLS(C), .WORD_SIZE(W), .BASE_ADDR(32'd16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .col_valid(col_valid), .bottom_out_bus(bus),
    .output_mem_wr_en(wr_en16), .output_mem_addr(addr16), .output_mem_wr_data(data16),
    .busy(busy16), .done(done16), .overflow(ov16)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int             cyc;
    logic [31:0]    addr;
    logic [C*W-1:0] data;
  } wr_t;

  wr_t  wlog[$];
  wr_t  wlog16[$];
  int   dlog[$];
  logic dbusy[$];

  always @(posedge clk) begin
    #1;
    if (wr_en0 === 1'b1)  wlog.push_back('{cyc, addr0, data0});
    if (wr_en16 === 1'b1) wlog16.push_back('{cyc, addr16, data16});
    if (done0 === 1'b1) begin
      dlog.push_back(cyc);
      dbusy.push_back(busy0);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] m [R][C];
  int           f [C];
  int           t0;

  function automatic logic [C*W-1:0] exp_row(input int r);
    logic [C*W-1:0] v;
    v = '0;
    for (int c = 0; c < C; c++) v[c*W +: W] = m[r][c];
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    wlog.delete();
    wlog16.delete();
    dlog.delete();
    dbusy.delete();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Column c delivers rows 0..R-1 on steps f[c]..f[c]+R-1; optional extra
  // beat on ov_c at step ov_t and a stray start at step st_t.
  task automatic run_sched(input int ov_t, input int ov_c, input int st_t);
    int last;
    last = 0;
    for (int c = 0; c < C; c++) if (f[c] + R - 1 > last) last = f[c] + R - 1;
    if (ov_t > last) last = ov_t;
    if (st_t > last) last = st_t;
    for (int t = 0; t <= last; t++) begin
      col_valid = '0;
      bus       = '0;
      for (int c = 0; c < C; c++) begin
        if (t >= f[c] && t < f[c] + R) begin
          col_valid[c] = 1'b1;
          bus[c*W +: W] = m[t-f[c]][c];
        end
      end
      if (t == ov_t) begin
        col_valid[ov_c] = 1'b1;
        bus[ov_c*W +: W] = 16'hBEEF;
      end
      start = (t == st_t);
      step();
    end
    col_valid = '0;
    bus       = '0;
    start     = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; col_valid = '0; bus = '0;
    repeat (3) step();
    n_tests++;
    if ({wr_en0, addr0, data0, busy0, done0, ov0} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h busy=%b done=%b ov=%b, want all 0",
               wr_en0, addr0, data0, busy0, done0, ov0);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_skew();
    m[0] = '{16'd67, 16'd43, 16'd81, 16'd23};
    m[1] = '{16'd85, 16'd101, 16'd173, 16'd38};
    m[2] = '{16'd80, 16'd114, 16'd232, 16'd43};
    m[3] = '{16'd71, 16'd94, 16'd220, 16'd37};
    f = '{0, 1, 2, 3};
    clear_logs();
    start_pulse();
    run_sched(-1, 0, -1);
    n_tests++;
    if (wlog.size() != R) begin
      n_fail++; $display("FAIL skew_count: got %0d writes, want %0d", wlog.size(), R);
    end
    // col 3 row r captured at edge t0+4+r; write follows one edge later.
    for (int r = 0; r < R && r < wlog.size(); r++) begin
      n_tests++;
      if (wlog[r].addr !== 32'(r) || wlog[r].data !== exp_row(r) || wlog[r].cyc != t0 + 5 + r) begin
        n_fail++;
        $display("FAIL skew_row%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 r, wlog[r].addr, wlog[r].data, wlog[r].cyc - t0, r, exp_row(r), 5 + r);
      end
    end
    n_tests++;
    if (dlog.size() != 1 || (dlog.size() == 1 && dlog[0] != t0 + 8)) begin
      n_fail++;
      $display("FAIL skew_done: got %0d pulses first at %0d, want 1 pulse at %0d",
               dlog.size(), (dlog.size() > 0) ? dlog[0] - t0 : -1, 8);
    end
  endtask

  task automatic test_all_valid();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = 16'(1000 + 10 * r + c);
    m[2][3] = 16'hFFFF;
    f = '{0, 0, 0, 0};
    clear_logs();
    start_pulse();
    n_tests++;
    if (busy0 !== 1'b1) begin
      n_fail++; $display("FAIL all_busy: got busy=%b, want 1", busy0);
    end
    run_sched(-1, 0, -1);
    for (int r = 0; r < R; r++) begin
      n_tests++;
      if (r >= wlog.size()) begin
        n_fail++; $display("FAIL all_row%0d: got no write, want addr=%0d", r, r);
      end else if (wlog[r].addr !== 32'(r) || wlog[r].data !== exp_row(r) || wlog[r].cyc != t0 + 2 + r) begin
        n_fail++;
        $display("FAIL all_row%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 r, wlog[r].addr, wlog[r].data, wlog[r].cyc - t0, r, exp_row(r), 2 + r);
      end
    end
    n_tests++;
    if (dlog.size() != 1 || (dlog.size() == 1 && (dlog[0] != t0 + 5 || dbusy[0] !== 1'b0))) begin
      n_fail++;
      $display("FAIL all_done: got %0d pulses at %0d busy=%b, want 1 pulse at 5 busy=0",
               dlog.size(), (dlog.size() > 0) ? dlog[0] - t0 : -1, (dbusy.size() > 0) ? dbusy[0] : 1'bx);
    end
    n_tests++;
    if (wlog.size() != R) begin
      n_fail++; $display("FAIL all_count: got %0d writes, want %0d", wlog.size(), R);
    end
  endtask

  task automatic test_stall();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = 16'(16'hA000 + 16 * r + c);
    f = '{0, 0, 8, 0};
    clear_logs();
    start_pulse();
    run_sched(-1, 0, -1);
    n_tests++;
    if (wlog.size() != R) begin
      n_fail++; $display("FAIL stall_count: got %0d writes, want %0d", wlog.size(), R);
    end
    // col 2 row 0 captured at edge t0+9, so the first write lands at t0+10.
    for (int r = 0; r < R && r < wlog.size(); r++) begin
      n_tests++;
      if (wlog[r].addr !== 32'(r) || wlog[r].data !== exp_row(r) || wlog[r].cyc != t0 + 10 + r) begin
        n_fail++;
        $display("FAIL stall_row%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 r, wlog[r].addr, wlog[r].data, wlog[r].cyc - t0, r, exp_row(r), 10 + r);
      end
    end
  endtask

  task automatic test_overflow();
    m[0] = '{16'd67, 16'd43, 16'd81, 16'd23};
    m[1] = '{16'd85, 16'd101, 16'd173, 16'd38};
    m[2] = '{16'd80, 16'd114, 16'd232, 16'd43};
    m[3] = '{16'd71, 16'd94, 16'd220, 16'd37};
    f = '{0, 0, 0, 6};
    clear_logs();
    start_pulse();
    run_sched(5, 1, -1);
    n_tests++;
    if (ov0 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got overflow=%b, want 1", ov0);
    end
    for (int r = 0; r < R; r++) begin
      n_tests++;
      if (r >= wlog.size()) begin
        n_fail++; $display("FAIL ovf_row%0d: got no write, want addr=%0d", r, r);
      end else if (wlog[r].addr !== 32'(r) || wlog[r].data !== exp_row(r)) begin
        n_fail++;
        $display("FAIL ovf_row%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 r, wlog[r].addr, wlog[r].data, r, exp_row(r));
      end
    end
    start_pulse();
    n_tests++;
    if (ov0 !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: got overflow=%b, want 0", ov0);
    end
    f = '{0, 0, 0, 0};
    clear_logs();
    run_sched(-1, 0, -1);
    n_tests++;
    if (wlog.size() != R || dlog.size() != 1) begin
      n_fail++;
      $display("FAIL ovf_rerun: got %0d writes %0d done, want %0d writes 1 done", wlog.size(), dlog.size(), R);
    end
  endtask

  task automatic test_start_ignored();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = 16'(16'h0300 + 16 * r + c);
    f = '{0, 0, 0, 0};
    clear_logs();
    start_pulse();
    run_sched(-1, 0, 1);
    for (int r = 0; r < R; r++) begin
      n_tests++;
      if (r >= wlog.size()) begin
        n_fail++; $display("FAIL restart_row%0d: got no write, want addr=%0d", r, r);
      end else if (wlog[r].addr !== 32'(r) || wlog[r].data !== exp_row(r) || wlog[r].cyc != t0 + 2 + r) begin
        n_fail++;
        $display("FAIL restart_row%0d: got addr=%0d data=%h cyc=%0d, want addr=%0d data=%h cyc=%0d",
                 r, wlog[r].addr, wlog[r].data, wlog[r].cyc - t0, r, exp_row(r), 2 + r);
      end
    end
    n_tests++;
    if (wlog.size() != R || dlog.size() != 1) begin
      n_fail++;
      $display("FAIL restart_count: got %0d writes %0d done, want %0d writes 1 done", wlog.size(), dlog.size(), R);
    end
    // start arriving while in DONE must not launch a new collection.
    clear_logs();
    start_pulse();
    run_sched(-1, 0, 5);
    n_tests++;
    if (busy0 !== 1'b0 || wlog.size() != R || dlog.size() != 1) begin
      n_fail++;
      $display("FAIL restart_in_done: got busy=%b writes=%0d done=%0d, want busy=0 writes=%0d done=1",
               busy0, wlog.size(), dlog.size(), R);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) m[r][c] = 16'(16'h5000 + 16 * r + c);
    f = '{0, 0, 0, 0};
    clear_logs();
    start_pulse();
    for (int t = 0; t < R; t++) begin
      col_valid = '1;
      for (int c = 0; c < C; c++) bus[c*W +: W] = m[t][c];
      if (t == 3) begin
        n_tests++;
        if (wlog.size() != 2) begin
          n_fail++; $display("FAIL rstmid_before: got %0d writes, want 2", wlog.size());
        end
        rst = 1'b1;
      end
      step();
    end
    n_tests++;
    if ({wr_en0, addr0, data0, busy0, done0, ov0, wr_en16, addr16, data16, busy16, done16, ov16} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got wr_en=%b addr=%0d busy=%b done=%b ov=%b wr_en16=%b addr16=%0d, want all 0",
               wr_en0, addr0, busy0, done0, ov0, wr_en16, addr16);
    end
    rst = 1'b0; col_valid = '0; bus = '0;
    repeat (6) step();
    n_tests++;
    if (wlog.size() != 2 || dlog.size() != 0) begin
      n_fail++;
      $display("FAIL rstmid_after: got %0d writes %0d done, want 2 writes 0 done", wlog.size(), dlog.size());
    end
    clear_logs();
    start_pulse();
    run_sched(-1, 0, -1);
    for (int r = 0; r < R; r++) begin
      n_tests++;
      if (r >= wlog16.size()) begin
        n_fail++; $display("FAIL base16_row%0d: got no write, want addr=%0d", r, 16 + r);
      end else if (wlog16[r].addr !== 32'(16 + r) || wlog16[r].data !== exp_row(r)) begin
        n_fail++;
        $display("FAIL base16_row%0d: got addr=%0d data=%h, want addr=%0d data=%h",
                 r, wlog16[r].addr, wlog16[r].data, 16 + r, exp_row(r));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_skew();
    test_all_valid();
    test_stall();
    test_overflow();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
